firtap_sequencer: RTL and testbench

Controller for a chain of adjustable-tap FIR stages. It accepts a stream of coefficients, shifts them into the tap chain through the shared tap-write strobe, and holds off sample processing while the chain is being reloaded. After a reload it qualifies filter outputs only once every product in the accumulator pipeline uses the new coefficient set. It sits between the coefficient source and sample source on one side and the filter's `i_tap_wr`/`i_tap`/`i_ce` inputs on the other.

---
 rtl/firtap_seq_pkg.sv | 16 +
 rtl/firtap_sequencer.sv | 149 ++++++++++++++
 tb/tb_firtap_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/firtap_seq_pkg.sv
// Shared types and sizing helpers for the FIR tap-reload sequencer.
package firtap_seq_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ZFILL = 2'd2,
    ST_FLUSH = 2'd3
  } seq_state_t;

  // Width of a counter that must hold values 0..terminal inclusive.
  function automatic int unsigned cnt_w(input int unsigned terminal);
    return (terminal < 1) ? 1 : $clog2(terminal + 1);
  endfunction

endpackage

// File: rtl/firtap_sequencer.sv
// Coefficient-reload controller for an adjustable-tap FIR chain.
// Shifts a coefficient set into the chain, gates the sample strobe while
// reloading, and withholds o_valid until the pipeline holds only new products.
// Optional: FIRTAP_SEQUENCER_ZEROFILL_EN pads a short coefficient set with zeros.
module firtap_sequencer
  import firtap_seq_pkg::*;
#(
  parameter int unsigned NTAPS     = 16,
  parameter int unsigned TW        = 16,
  parameter int unsigned FLUSH_LEN = NTAPS + 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load_start,
  input  logic          i_coef_valid,
  output logic          o_coef_ready,
  input  logic [TW-1:0] i_coef,
  input  logic          i_coef_last,
  output logic          o_tap_wr,
  output logic [TW-1:0] o_tap,
  input  logic          i_ce,
  output logic          o_ce,
  output logic          o_valid,
  output logic          o_busy,
  output logic          o_drop,
  output logic          o_err
);

  localparam int unsigned TCW = cnt_w(NTAPS);
  localparam int unsigned SCW = cnt_w(FLUSH_LEN);
  localparam logic [TCW-1:0] TCNT_TERM = TCW'(NTAPS);
  localparam logic [TCW-1:0] TCNT_LAST = TCW'(NTAPS - 1);
  localparam logic [SCW-1:0] SCNT_TERM = SCW'(FLUSH_LEN);
  localparam logic [SCW-1:0] SCNT_LAST = SCW'(FLUSH_LEN - 1);

  seq_state_t       r_state, w_state_nxt;
  logic [TCW-1:0]   r_tcnt,  w_tcnt_nxt;
  logic [SCW-1:0]   r_scnt,  w_scnt_nxt;
  logic [TW-1:0]    r_tap,   w_tap_nxt;
  logic             r_tap_wr, w_tap_wr_nxt;
  logic             r_err,   w_err_nxt;
  logic [TCW-1:0]   w_tcnt_inc;
  logic [SCW-1:0]   w_scnt_inc;

  assign w_tcnt_inc = (r_tcnt < TCNT_TERM) ? r_tcnt + TCW'(1) : r_tcnt;
  assign w_scnt_inc = (r_scnt < SCNT_TERM) ? r_scnt + SCW'(1) : r_scnt;

  assign o_tap    = r_tap;
  assign o_tap_wr = r_tap_wr;
  assign o_err    = r_err;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_RUN;
    else         r_state <= w_state_nxt;
  end

  // Counters and registered tap/error outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tcnt   <= '0;
      r_scnt   <= '0;
      r_tap    <= '0;
      r_tap_wr <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_tcnt   <= w_tcnt_nxt;
      r_scnt   <= w_scnt_nxt;
      r_tap    <= w_tap_nxt;
      r_tap_wr <= w_tap_wr_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Next state, counter updates and the combinational sample-path outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_tcnt_nxt   = r_tcnt;
    w_scnt_nxt   = r_scnt;
    w_tap_nxt    = r_tap;
    w_tap_wr_nxt = 1'b0;
    w_err_nxt    = 1'b0;
    o_coef_ready = 1'b0;
    o_ce         = 1'b0;
    o_valid      = 1'b0;
    o_busy       = 1'b0;
    o_drop       = 1'b0;

    case (r_state)
      ST_RUN: begin
        o_ce    = i_ce;
        o_valid = i_ce;
        if (i_load_start) begin
          w_state_nxt = ST_LOAD;
          w_tcnt_nxt  = '0;
          w_scnt_nxt  = '0;
        end
      end

      ST_LOAD: begin
        o_coef_ready = 1'b1;
        o_busy       = 1'b1;
        o_drop       = i_ce;
        if (i_coef_valid) begin
          w_tap_nxt    = i_coef;
          w_tap_wr_nxt = 1'b1;
          w_tcnt_nxt   = w_tcnt_inc;
          if (r_tcnt == TCNT_LAST) begin
            w_state_nxt = ST_FLUSH;
            w_err_nxt   = ~i_coef_last;
          end else if (i_coef_last) begin
            w_err_nxt = 1'b1;
`ifdef FIRTAP_SEQUENCER_ZEROFILL_EN
            w_state_nxt = ST_ZFILL;
`endif
          end
        end
      end

`ifdef FIRTAP_SEQUENCER_ZEROFILL_EN
      // Pad the taps nearest the input with zeros until NTAPS writes are done.
      ST_ZFILL: begin
        o_busy       = 1'b1;
        o_drop       = i_ce;
        w_tap_nxt    = '0;
        w_tap_wr_nxt = 1'b1;
        w_tcnt_nxt   = w_tcnt_inc;
        if (r_tcnt == TCNT_LAST) w_state_nxt = ST_FLUSH;
      end
`endif

      ST_FLUSH: begin
        o_busy = 1'b1;
        o_ce   = i_ce;
        if (i_load_start) begin
          w_state_nxt = ST_LOAD;
          w_tcnt_nxt  = '0;
          w_scnt_nxt  = '0;
        end else if (i_ce) begin
          w_scnt_nxt = w_scnt_inc;
          if (r_scnt == SCNT_LAST) w_state_nxt = ST_RUN;
        end
      end

      default: w_state_nxt = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_firtap_sequencer.sv
// Randomized scoreboard bench for firtap_sequencer against a counting model.
module tb_firtap_sequencer;

  localparam int unsigned NTAPS     = 16;
  localparam int unsigned TW        = 16;
  localparam int unsigned FLUSH_LEN = NTAPS + 2;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_load_start = 1'b0;
  logic          i_coef_valid = 1'b0;
  logic [TW-1:0] i_coef = '0;
  logic          i_coef_last = 1'b0;
  logic          i_ce = 1'b0;
  logic          o_coef_ready, o_tap_wr, o_ce, o_valid, o_busy, o_drop, o_err;
  logic [TW-1:0] o_tap;

  firtap_sequencer #(.NTAPS(NTAPS), .TW(TW), .FLUSH_LEN(FLUSH_LEN)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_load_start(i_load_start),
    .i_coef_valid(i_coef_valid), .o_coef_ready(o_coef_ready), .i_coef(i_coef),
    .i_coef_last(i_coef_last), .o_tap_wr(o_tap_wr), .o_tap(o_tap), .i_ce(i_ce),
    .o_ce(o_ce), .o_valid(o_valid), .o_busy(o_busy), .o_drop(o_drop), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit chk;
    bit rdy, ce, vld, drp, bsy;
  } cyc_exp_t;
  typedef struct {
    int            due;
    logic [TW-1:0] val;
  } tap_exp_t;

  cyc_exp_t q_cyc[$];
  tap_exp_t q_tap[$];
  int       q_err[$];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

  // Reference model: what the chain still needs, in plain counts.
  bit m_loading = 1'b0;
  int m_nacc = 0;
  int m_zeros_left = 0;
  int m_flush_left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
  endtask

  function automatic bit m_busy();
    return m_loading || (m_zeros_left > 0) || (m_flush_left > 0);
  endfunction

  // Drive one cycle of inputs and record what the DUT must do.
  task automatic step(input bit ls, input bit cv, input logic [TW-1:0] c,
                      input bit cl, input bit ce, input bit rst);
    cyc_exp_t e;
    tap_exp_t t;
    @(posedge clk); #1;
    i_load_start = ls; i_coef_valid = cv; i_coef = c; i_coef_last = cl;
    i_ce = ce; i_reset = rst;
    e.chk = !rst; e.rdy = 0; e.ce = 0; e.vld = 0; e.drp = 0; e.bsy = 0;
    if (m_loading) begin
      e.rdy = 1; e.drp = ce; e.bsy = 1;
      if (cv) begin
        m_nacc++;
        t.due = cyc + 1; t.val = c;
        if (!rst) q_tap.push_back(t);
        if (m_nacc == int'(NTAPS)) begin
          if (!cl && !rst) q_err.push_back(cyc + 1);
          m_loading = 0;
          m_flush_left = FLUSH_LEN;
        end else if (cl) begin
          if (!rst) q_err.push_back(cyc + 1);
`ifdef FIRTAP_SEQUENCER_ZEROFILL_EN
          m_loading = 0;
          m_zeros_left = NTAPS - m_nacc;
`endif
        end
      end
    end else if (m_zeros_left > 0) begin
      e.drp = ce; e.bsy = 1;
      t.due = cyc + 1; t.val = '0;
      if (!rst) q_tap.push_back(t);
      m_zeros_left--;
      if (m_zeros_left == 0) m_flush_left = FLUSH_LEN;
    end else if (m_flush_left > 0) begin
      e.ce = ce; e.bsy = 1;
      if (ls) begin
        m_loading = 1; m_nacc = 0; m_flush_left = 0;
      end else if (ce) begin
        m_flush_left--;
      end
    end else begin
      e.ce = ce; e.vld = ce;
      if (ls) begin
        m_loading = 1; m_nacc = 0;
      end
    end
    if (rst) begin
      m_loading = 0; m_nacc = 0; m_zeros_left = 0; m_flush_left = 0;
    end
    q_cyc.push_back(e);
  endtask

  function automatic bit ce_bit(input int mode);
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  // Request a reload and offer up to n coefficients.
  task automatic do_load(input int n, input int last_at, input int ce_mode,
                         input bit gaps, input bit seq_vals, input int rst_at);
    int k = 0;
    int guard = 0;
    step(1, 0, '0, 0, ce_bit(ce_mode), 0);
    while (m_loading && k < n && guard < 400) begin
      bit cv;
      logic [TW-1:0] c;
      guard++;
      cv = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cv) k++;
      c = seq_vals ? TW'(k) : TW'($urandom);
      step(0, cv, c, cv && (k == last_at), ce_bit(ce_mode), cv && (k == rst_at));
    end
  endtask

  // Run samples until the model reports the sequencer idle.
  task automatic wait_idle(input int ce_mode, input int bound);
    int g = 0;
    while (m_busy() && g < bound) begin
      g++;
      step(0, 0, '0, 0, ce_bit(ce_mode), 0);
    end
    check("idle_timeout", 32'(m_busy()), 32'd0);
  endtask

  // Monitor: compares every cycle's outputs against the scoreboard queues.
  always @(negedge clk) begin
    cyc_exp_t e;
    tap_exp_t t;
    bit exp_wr, exp_err;
    if (q_cyc.size() > 0) begin
      e = q_cyc.pop_front();
      if (e.chk) begin
        check("coef_ready", 32'(o_coef_ready), 32'(e.rdy));
        check("ce",         32'(o_ce),         32'(e.ce));
        check("valid",      32'(o_valid),      32'(e.vld));
        check("drop",       32'(o_drop),       32'(e.drp));
        check("busy",       32'(o_busy),       32'(e.bsy));
      end
    end
    if (mon_en) begin
      exp_wr = (q_tap.size() > 0) && (q_tap[0].due == cyc);
      check("tap_wr", 32'(o_tap_wr), 32'(exp_wr));
      if (exp_wr) begin
        t = q_tap.pop_front();
        if (o_tap_wr) check("tap", 32'(o_tap), 32'(t.val));
      end
      exp_err = (q_err.size() > 0) && (q_err[0] == cyc);
      check("err", 32'(o_err), 32'(exp_err));
      if (exp_err) void'(q_err.pop_front());
    end
  end

  initial begin
    // Reset and the reset-state outputs.
    repeat (3) step(0, 0, '0, 0, 0, 1);
    step(0, 0, '0, 0, 0, 0);
    mon_en = 1'b1;
    #1;
    check("rst_tap",    32'(o_tap),        32'd0);
    check("rst_tap_wr", 32'(o_tap_wr),     32'd0);
    check("rst_err",    32'(o_err),        32'd0);
    check("rst_ready",  32'(o_coef_ready), 32'd0);
    check("rst_busy",   32'(o_busy),       32'd0);
    check("rst_ce",     32'(o_ce),         32'd0);
    check("rst_valid",  32'(o_valid),      32'd0);
    check("rst_drop",   32'(o_drop),       32'd0);

    // Samples every second cycle in RUN.
    for (int i = 0; i < 20; i++) step(0, 0, '0, 0, 1'(i % 2), 0);

    // Full reload 1..16, then flush with random samples.
    do_load(NTAPS, NTAPS, 0, 0, 1, -1);
    wait_idle(2, 400);
    for (int i = 0; i < 6; i++) step(0, 0, '0, 0, 1, 0);

    // Samples held high during a gapped load.
    do_load(NTAPS, NTAPS, 1, 1, 0, -1);
    wait_idle(1, 400);

    // Early last on coefficient 10, then offer the rest if still loading.
    do_load(NTAPS, 10, 2, 0, 1, -1);
    wait_idle(2, 400);

    // Last never asserted.
    do_load(NTAPS, -1, 0, 0, 0, -1);
    wait_idle(1, 400);

    // Reset at coefficient 5.
    do_load(NTAPS, NTAPS, 0, 0, 1, 5);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0, 1'(i % 2), 0);

    // Restart during FLUSH.
    do_load(NTAPS, NTAPS, 0, 0, 0, -1);
    for (int i = 0; i < 5; i++) step(0, 0, '0, 0, 1, 0);
    do_load(NTAPS, NTAPS, 2, 0, 1, -1);
    wait_idle(2, 400);

    // Random soak.
    for (int i = 0; i < 2500; i++) begin
      step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), TW'($urandom),
           1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 399) == 0));
    end
    wait_idle(1, 400);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 0, 0, 0);
    @(posedge clk); #1;

    check("tap_queue_empty", 32'(q_tap.size()), 32'd0);
    check("err_queue_empty", 32'(q_err.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
